seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//   Parametrised multi-cycle add/subtract unit: successor to the team's 4-bit combinational adder.
//   Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a register.
//   Uses valid/ready handshakes on input and output, and reports carry-out and signed overflow.
//   Sits between operand registers and the result/display path in lab datapaths.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  4  bits processed per cycle; CHUNK==WIDTH gives a 1-cycle adder
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands/mode valid this cycle
//   in_ready   out  1      block can accept operands
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   Cin        in   1      carry-in (add mode only; ignored when Sub=1)
//   Sub        in   1      0: S=A+B+Cin; 1: S=A-B (A+~B+1)
//   out_valid  out  1      result valid; held until accepted
//   out_ready  in   1      consumer accepts result
//   S          out  WIDTH  result, modulo 2^WIDTH
//   Cout       out  1      carry out of MSB (Sub=1: 1 = no borrow)
//   Ovf        out  1      two's-complement overflow
// BEHAVIOUR
//   - One clock; reset is asynchronous, active-high. While rst is high: state=IDLE, S=0, Cout=0, Ovf=0,
//     out_valid=0, in_ready=0. After release: in_ready=1.
//   - FSM IDLE -> RUN -> DONE -> IDLE. NCH = WIDTH/CHUNK.
//   - IDLE: in_ready=1. On in_valid&&in_ready: capture A, B^{WIDTH{Sub}}, carry = Sub ? 1 : Cin, clear chunk index; go to RUN.
//   - RUN: in_ready=0. Each cycle, chunk k = [k*CHUNK +: CHUNK] is added with the registered carry.
//     The sum is written to S[k], the chunk carry is registered, and k increments.
//     After chunk NCH-1: latch Cout and Ovf = carry-in(MSB) ^ carry-out(MSB); go to DONE.
//   - Latency: out_valid rises exactly NCH cycles after the accepting edge.
//   - DONE: out_valid=1. S, Cout and Ovf are stable. On out_ready: out_valid=0 at the next edge, go to IDLE.
//     Back-to-back throughput is therefore 1 op per NCH+2 cycles.
//   - Outputs hold their last result in IDLE; S is overwritten chunk-by-chunk during RUN.
//     Consumers sample S only when out_valid=1.
//   - in_valid while not IDLE is ignored (no queuing). out_ready outside DONE is ignored.
//   - Reset mid-RUN or mid-DONE aborts the operation immediately with no partial result flagged.
//   - Elaboration error if WIDTH%CHUNK != 0 or CHUNK < 1.
// STRUCTURE
//   - Shared package adder_pkg (`include): state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit) and a clog2 helper
//     for the chunk-index width.
//   - Sub-module adder_chunk #(CHUNK): combinational ripple adder with ports a, b, cin, s, cout, plus c_msb
//     (carry into the top bit, for overflow). It is instantiated once.
//   - Top level contains the FSM, operand/carry/index registers and the output registers.
// TESTING  (WIDTH=8, CHUNK=4 unless noted)
//   - 0x0F+0x01, Cin=0 -> S=0x10, Cout=0, Ovf=0 (inter-chunk carry); out_valid exactly 2 cycles after accept.
//   - 0xFF+0x01 -> S=0x00, Cout=1, Ovf=0; 0x7F+0x01 -> S=0x80, Cout=0, Ovf=1.
//   - Sub: 0x05-0x07 -> S=0xFE, Cout=0, Ovf=0; 0x80-0x01 -> S=0x7F, Cout=1, Ovf=1.
//   - Backpressure: out_ready low 3 cycles -> S, Cout and out_valid held, in_ready=0, a new in_valid is ignored;
//     then out_ready=1 -> IDLE.
//   - Assert rst during RUN -> all outputs 0 asynchronously; after release, 0x12+0x34 -> 0x46.
//   - CHUNK=8: 0xF0+0x0F+Cin=1 -> S=0x00, Cout=1 with 1-cycle latency.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encodings
// and the width helper for the chunk index register.
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // At least one bit, so a single-chunk configuration still has a legal index register.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its top bit
// so the caller can derive two's-complement overflow on the final slice.
module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign s     = full[CHUNK-1:0];
   assign cout  = full[CHUNK];
   // The top sum bit is a^b^carry_in, so the carry into it falls out by xor.
   assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock with a registered
// inter-chunk carry, valid/ready handshakes on both sides.
module seq_chunk_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = idx_width(NCH);

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IW-1:0]    idx;
   int               base;
   logic             accept;
   logic             last;
   logic [CHUNK-1:0] ch_s;
   logic             ch_cout;
   logic             ch_cmsb;

   assign accept = (state == ST_IDLE) && in_valid && in_ready;
   assign last   = (idx == IW'(NCH - 1));
   assign base   = int'(idx) * CHUNK;

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_q[base +: CHUNK]),
      .b     (b_q[base +: CHUNK]),
      .cin   (carry_q),
      .s     (ch_s),
      .cout  (ch_cout),
      .c_msb (ch_cmsb)
   );

   // Subtraction is folded in at capture time: B is inverted here and the +1 rides in on the carry.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= A;
         b_q <= B ^ {WIDTH{Sub}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         carry_q   <= 1'b0;
         idx       <= '0;
         S         <= '0;
         Cout      <= 1'b0;
         Ovf       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  carry_q  <= Sub | Cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               S[base +: CHUNK] <= ch_s;
               carry_q          <= ch_cout;
               idx              <= idx + IW'(1);
               if (last) begin
                  Cout      <= ch_cout;
                  Ovf       <= ch_cmsb ^ ch_cout;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: protocol-level reference model checked every cycle,
// plus directed operations with hand-computed results (WIDTH=8, CHUNK=4 and CHUNK=8).
module tb_seq_chunk_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout, Ovf;
   logic [7:0] A, B, S;
   logic       in_valid2, in_ready2, Cin2, Sub2, out_valid2, out_ready2, Cout2, Ovf2;
   logic [7:0] A2, B2, S2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Sub(Sub),
      .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout), .Ovf(Ovf)
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .A(A2), .B(B2), .Cin(Cin2), .Sub(Sub2),
      .out_valid(out_valid2), .out_ready(out_ready2), .S(S2), .Cout(Cout2), .Ovf(Ovf2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference arithmetic on integers: returns {ovf, cout, s}.
   function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
      int ua, ub, sa, sb, ur, sr;
      logic c, o;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub + int'(cin);
         sr = sa + sb + int'(cin);
         c  = (ur > 255);
      end
      o = (sr > 127) || (sr < -128);
      return {o, c, ur[7:0]};
   endfunction

   // Protocol-level model: accept when ready, result appears 2 cycles later, held until taken.
   logic       m_valid = 1'b0, m_ready = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
   logic [7:0] m_s = 8'h00;
   int         m_cnt = 0;
   logic [7:0] pa, pb;
   logic       pcin, psub;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_ready <= 1'b0;
         m_cnt   <= 0;
         m_s     <= 8'h00;
         m_cout  <= 1'b0;
         m_ovf   <= 1'b0;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
         end
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_valid <= 1'b1;
            {m_ovf, m_cout, m_s} <= ref_op(pa, pb, pcin, psub);
         end
      end else begin
         m_ready <= 1'b1;
         if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            m_cnt   <= 2;
            pa      <= A;
            pb      <= B;
            pcin    <= Cin;
            psub    <= Sub;
         end
      end
   end

   always @(negedge clk) begin
      chk("mdl_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("mdl_in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      if (m_valid || rst) begin
         chk("mdl_S", {24'd0, S}, {24'd0, m_s});
         chk("mdl_Cout", {31'd0, Cout}, {31'd0, m_cout});
         chk("mdl_Ovf", {31'd0, Ovf}, {31'd0, m_ovf});
      end
   end

   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sub, input string name);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [7:0] es, input logic ec,
                         input logic eo, input string name);
      int lat;
      start_op(a, b, cin, sub, name);
      wait_valid(lat);
      chk({name, "_latency"}, lat, 32'd2);
      chk({name, "_S"}, {24'd0, S}, {24'd0, es});
      chk({name, "_Cout"}, {31'd0, Cout}, {31'd0, ec});
      chk({name, "_Ovf"}, {31'd0, Ovf}, {31'd0, eo});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_released"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      rst = 1'b0;
      in_valid = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; A2 = 8'h00; B2 = 8'h00; Cin2 = 1'b0; Sub2 = 1'b0; out_ready2 = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_S", {24'd0, S}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_in_ready8", {31'd0, in_ready2}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
      run_op(8'h3C, 8'h44, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, "add_cin");
      run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
      run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
      run_op(8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "sub_cin_ignored");

      // Backpressure: result held while out_ready is low, new requests ignored.
      start_op(8'hA5, 8'h5A, 1'b0, 1'b0, "bp");
      wait_valid(lat);
      chk("bp_latency", lat, 32'd2);
      for (int i = 0; i < 3; i++) begin
         A = 8'h01; B = 8'h01; in_valid = 1'b1;
         @(posedge clk); #1;
         chk("bp_S_held", {24'd0, S}, 32'hFF);
         chk("bp_Cout_held", {31'd0, Cout}, 32'd0);
         chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_done_out_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_done_in_ready", {31'd0, in_ready}, 32'd1);

      // Asynchronous reset in the middle of an operation.
      start_op(8'hAB, 8'h11, 1'b0, 1'b0, "abort");
      #2 rst = 1'b1;
      #1;
      chk("abort_S", {24'd0, S}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_Cout_Ovf", {30'd0, Cout, Ovf}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "after_abort");

      // Single-chunk instance: one-cycle latency.
      lat = 0;
      while (!in_ready2 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("c8_in_ready", {31'd0, in_ready2}, 32'd1);
      A2 = 8'hF0; B2 = 8'h0F; Cin2 = 1'b1; Sub2 = 1'b0; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat = 0;
      while (!out_valid2 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("c8_latency", lat, 32'd1);
      chk("c8_S", {24'd0, S2}, 32'd0);
      chk("c8_Cout", {31'd0, Cout2}, 32'd1);
      chk("c8_Ovf", {31'd0, Ovf2}, 32'd0);
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      chk("c8_released", {31'd0, out_valid2}, 32'd0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
